fifo_read_scheduler: RTL and testbench
======================================

Name: fifo_read_scheduler

Overview:
- Shares one FIFO byte-serializer (the FIFO reader helper) among N_REQ requesters using round-robin arbitration.
- Per granted transfer: latches the requester's byte length, drives the helper's read request and buffer length, counts serialized bytes to detect completion, and reports done/error per transfer.
- Enforces a cool-down after each transfer so the helper is back in its idle state before it sees the next request.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- LEN_W, 6, width of a byte length; matches the helper buffer-length port.
- TIMEOUT, 255, maximum consecutive cycles without a valid byte before a transfer is aborted (1..255).
- COOL, 4, idle cycles after a transfer before the next grant (>=4).

Ports:
- CLK  in  1  clock, all logic on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- i_req  in  N_REQ  per-requester request level; held until that requester's o_done.
- i_req_len  in  N_REQ*LEN_W  packed lengths; requester k at bits [k*LEN_W +: LEN_W].
- o_grant  out  N_REQ  one-hot owner of the serializer; 0 when idle.
- o_read_request  out  1  to helper Read_Request.
- o_buffer_length  out  LEN_W  to helper buffer-length input; latched length of the owner.
- i_fifo_empty  in  1  FIFO empty flag, shared with the helper.
- i_ser_valid  in  1  helper serialized_output_valid.
- o_done  out  1  one-cycle pulse at transfer end.
- o_done_id  out  3  index of the finished requester; valid with o_done.
- o_done_bytes  out  LEN_W  bytes actually delivered; valid with o_done.
- o_error  out  1  with o_done: 1 = timeout abort, 0 = normal completion.

Behaviour:
- Reset (async, RESET=1): all outputs 0, state IDLE, rr_ptr=0, counters 0.
- States: IDLE, ISSUE, STREAM, DONE, COOL_DN.
- IDLE: o_grant=0 and o_read_request=0.
  - If any i_req=1 and i_fifo_empty=0: winner = first set request at index >= rr_ptr, wrapping modulo N_REQ.
  - Latch the winner's index and length; set o_grant one-hot; go to ISSUE.
  - If the latched length is 0: go directly to DONE with byte_cnt=0, o_error=0; the helper is never requested.
- ISSUE:
  - o_read_request=1; o_buffer_length = latched length, stable from ISSUE through COOL_DN.
  - On the first i_ser_valid=1: byte_cnt=1, go to STREAM. If the length is 1, go to DONE instead.
  - If TIMEOUT cycles pass with no valid: go to DONE with o_error=1.
- STREAM: o_read_request=0.
  - Each cycle with i_ser_valid=1: byte_cnt+1, reset the idle counter.
  - When byte_cnt reaches the latched length: go to DONE with o_error=0.
  - If valid stays low for TIMEOUT consecutive cycles (e.g. FIFO ran dry and the helper returned to idle early): go to DONE with o_error=1.
  - Valid bytes beyond the length are not counted.
- DONE, exactly one cycle:
  - o_done=1; o_done_id = owner; o_done_bytes = byte_cnt; o_error as above.
  - rr_ptr = (owner+1) mod N_REQ.
  - o_grant stays set this cycle; go to COOL_DN.
- COOL_DN: o_grant=0; wait COOL cycles, then IDLE. This covers trailing non-valid serialize slots when the length is not a multiple of 4.
- Latency: IDLE to o_read_request = 1 cycle. Last valid byte to o_done = 1 cycle. o_done to next grant = COOL+1 cycles.
- Request deassertion mid-transfer is ignored; the transfer runs to DONE.
- New requests during a transfer wait for arbitration in IDLE.
- Counters: byte_cnt is LEN_W bits, so there is no wrap because length <= 2^LEN_W-1. The timeout counter is 8 bits and saturates.
- RESET during any state aborts immediately: no o_done, outputs 0, and o_read_request drops asynchronously.

Test Plan:
- Single requester: req[0]=1, len=8, FIFO non-empty, valid 8 cycles -> o_read_request high 1 cycle before the first valid; o_done 1 cycle after the 8th valid; id=0, bytes=8, error=0.
- Round-robin: req=4'b1111, all len=4 -> grant order 0,1,2,3,0; each done carries bytes=4; exactly COOL+1 cycles from o_done to the next o_grant.
- Odd length: len=5, helper emits 5 valid then 3 invalid slots -> done after byte 5; o_grant stays 0 through COOL_DN, and o_read_request stays 0 for the next 4 cycles.
- Zero length: req[2]=1, len=0 -> o_done, id=2, bytes=0, error=0 with no o_read_request pulse.
- Underflow: len=12, valid stops after 4 bytes -> TIMEOUT cycles later o_done with bytes=4, error=1; rr_ptr advances.
- Reset mid-STREAM: RESET asserted after 3 bytes -> all outputs 0 in the same cycle, no o_done. After release, pending req[1] is granted starting with rr_ptr=0.

Source files
------------

// File: rtl/fifo_read_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : fifo_read_scheduler
// Description : Round-robin sharing of one FIFO byte-serializer among N_REQ
//               requesters, with per-transfer byte counting and timeout abort.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_read_scheduler #(
  parameter int N_REQ   = 4,
  parameter int LEN_W   = 6,
  parameter int TIMEOUT = 255,
  parameter int COOL    = 4
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [N_REQ-1:0]       i_req,
  input  logic [N_REQ*LEN_W-1:0] i_req_len,
  output logic [N_REQ-1:0]       o_grant,
  output logic                   o_read_request,
  output logic [LEN_W-1:0]       o_buffer_length,
  input  logic                   i_fifo_empty,
  input  logic                   i_ser_valid,
  output logic                   o_done,
  output logic [2:0]             o_done_id,
  output logic [LEN_W-1:0]       o_done_bytes,
  output logic                   o_error
);

  localparam int              c_cool_w    = $clog2(COOL);
  localparam logic [c_cool_w-1:0] c_cool_last = c_cool_w'(COOL - 2);
  localparam logic [7:0]      c_to_last   = 8'(TIMEOUT - 1);
  localparam logic [2:0]      c_last_idx  = 3'(N_REQ - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_STREAM  = 3'd2,
    S_DONE    = 3'd3,
    S_COOL_DN = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_nxt_state;
  logic [2:0]          r_owner;
  logic [2:0]          r_rr_ptr;
  logic [LEN_W-1:0]    r_len;
  logic [LEN_W-1:0]    r_byte_cnt;
  logic [7:0]          r_to_cnt;
  logic [c_cool_w-1:0] r_cool_cnt;
  logic                r_err;

  logic                w_win_found;
  logic [2:0]          w_win_idx;
  logic [LEN_W-1:0]    w_win_len;
  logic                w_latch;
  logic [2:0]          w_rr_nxt;
  logic [LEN_W-1:0]    w_byte_cnt_nxt;
  logic [LEN_W-1:0]    w_byte_inc;
  logic [7:0]          w_to_cnt_nxt;
  logic [7:0]          w_to_inc;
  logic                w_to_hit;
  logic [c_cool_w-1:0] w_cool_nxt;
  logic                w_err_nxt;
  logic [N_REQ-1:0]    w_owner_oh;

  // Round-robin search: first set request at or after r_rr_ptr, wrapping.
  always_comb begin
    int v_idx;
    v_idx       = 0;
    w_win_found = 1'b0;
    w_win_idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      v_idx = int'(r_rr_ptr) + i;
      if (v_idx >= N_REQ) v_idx = v_idx - N_REQ;
      if (!w_win_found && i_req[v_idx]) begin
        w_win_found = 1'b1;
        w_win_idx   = 3'(v_idx);
      end
    end
  end

  assign w_win_len  = i_req_len[int'(w_win_idx)*LEN_W +: LEN_W];
  assign w_owner_oh = N_REQ'(1) << r_owner;
  assign w_byte_inc = r_byte_cnt + LEN_W'(1);
  assign w_to_inc   = (r_to_cnt == 8'hFF) ? r_to_cnt : r_to_cnt + 8'd1;
  assign w_to_hit   = !i_ser_valid && (r_to_cnt == c_to_last);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) r_state <= S_IDLE;
    else       r_state <= w_nxt_state;
  end

  always_comb begin
    w_nxt_state     = r_state;
    w_latch         = 1'b0;
    w_rr_nxt        = r_rr_ptr;
    w_byte_cnt_nxt  = r_byte_cnt;
    w_to_cnt_nxt    = r_to_cnt;
    w_cool_nxt      = r_cool_cnt;
    w_err_nxt       = r_err;
    o_grant         = '0;
    o_read_request  = 1'b0;
    o_buffer_length = '0;
    o_done          = 1'b0;
    o_done_id       = '0;
    o_done_bytes    = '0;
    o_error         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_win_found && !i_fifo_empty) begin
          w_latch        = 1'b1;
          w_byte_cnt_nxt = '0;
          w_to_cnt_nxt   = '0;
          w_err_nxt      = 1'b0;
          w_nxt_state    = (w_win_len == '0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        o_grant         = w_owner_oh;
        o_read_request  = 1'b1;
        o_buffer_length = r_len;
        if (i_ser_valid) begin
          w_byte_cnt_nxt = LEN_W'(1);
          w_to_cnt_nxt   = '0;
          w_nxt_state    = (r_len == LEN_W'(1)) ? S_DONE : S_STREAM;
        end else if (w_to_hit) begin
          w_err_nxt   = 1'b1;
          w_nxt_state = S_DONE;
        end else begin
          w_to_cnt_nxt = w_to_inc;
        end
      end
      S_STREAM: begin
        o_grant         = w_owner_oh;
        o_buffer_length = r_len;
        if (i_ser_valid) begin
          w_byte_cnt_nxt = w_byte_inc;
          w_to_cnt_nxt   = '0;
          if (w_byte_inc == r_len) w_nxt_state = S_DONE;
        end else if (w_to_hit) begin
          w_err_nxt   = 1'b1;
          w_nxt_state = S_DONE;
        end else begin
          w_to_cnt_nxt = w_to_inc;
        end
      end
      S_DONE: begin
        o_grant         = w_owner_oh;
        o_buffer_length = r_len;
        o_done          = 1'b1;
        o_done_id       = r_owner;
        o_done_bytes    = r_byte_cnt;
        o_error         = r_err;
        w_rr_nxt        = (r_owner == c_last_idx) ? 3'd0 : r_owner + 3'd1;
        w_cool_nxt      = '0;
        w_nxt_state     = S_COOL_DN;
      end
      S_COOL_DN: begin
        // COOL-1 cycles here plus the arbitration cycle in IDLE give COOL
        // grant-free cycles, so the next grant lands COOL+1 after o_done.
        o_buffer_length = r_len;
        if (r_cool_cnt == c_cool_last) w_nxt_state = S_IDLE;
        else                           w_cool_nxt  = r_cool_cnt + c_cool_w'(1);
      end
      default: w_nxt_state = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_owner    <= '0;
      r_rr_ptr   <= '0;
      r_len      <= '0;
      r_byte_cnt <= '0;
      r_to_cnt   <= '0;
      r_cool_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_latch) begin
        r_owner <= w_win_idx;
        r_len   <= w_win_len;
      end
      r_rr_ptr   <= w_rr_nxt;
      r_byte_cnt <= w_byte_cnt_nxt;
      r_to_cnt   <= w_to_cnt_nxt;
      r_cool_cnt <= w_cool_nxt;
      r_err      <= w_err_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_read_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_read_scheduler
// Description : Directed self-checking bench for fifo_read_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_read_scheduler;

  localparam int N_REQ   = 4;
  localparam int LEN_W   = 6;
  localparam int TIMEOUT = 16;
  localparam int COOL    = 4;

  logic                   CLK;
  logic                   RESET;
  logic [N_REQ-1:0]       i_req;
  logic [N_REQ*LEN_W-1:0] i_req_len;
  logic [N_REQ-1:0]       o_grant;
  logic                   o_read_request;
  logic [LEN_W-1:0]       o_buffer_length;
  logic                   i_fifo_empty;
  logic                   i_ser_valid;
  logic                   o_done;
  logic [2:0]             o_done_id;
  logic [LEN_W-1:0]       o_done_bytes;
  logic                   o_error;

  int n_checks = 0;
  int n_fail   = 0;

  fifo_read_scheduler #(
    .N_REQ(N_REQ), .LEN_W(LEN_W), .TIMEOUT(TIMEOUT), .COOL(COOL)
  ) u_dut (
    .CLK(CLK), .RESET(RESET), .i_req(i_req), .i_req_len(i_req_len),
    .o_grant(o_grant), .o_read_request(o_read_request),
    .o_buffer_length(o_buffer_length), .i_fifo_empty(i_fifo_empty),
    .i_ser_valid(i_ser_valid), .o_done(o_done), .o_done_id(o_done_id),
    .o_done_bytes(o_done_bytes), .o_error(o_error)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET       = 1'b1;
    i_req       = '0;
    i_ser_valid = 1'b0;
    tick();
    tick();
    RESET = 1'b0;
  endtask

  task automatic set_len(input int k, input int len);
    i_req_len[k*LEN_W +: LEN_W] = LEN_W'(len);
  endtask

  task automatic stream(input int nbytes);
    i_ser_valid = 1'b1;
    for (int i = 0; i < nbytes; i++) tick();
    i_ser_valid = 1'b0;
  endtask

  // Ticks at least once, then until a grant appears; returns the tick count.
  task automatic wait_grant(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (o_grant == '0 && n < 30);
  endtask

  int  n;
  int  ord[5] = '{0, 1, 2, 3, 0};
  logic bad;

  initial begin
    RESET        = 1'b1;
    i_req        = '0;
    i_req_len    = '0;
    i_fifo_empty = 1'b1;
    i_ser_valid  = 1'b0;
    do_reset();

    chk("rst_grant", o_grant, 0);
    chk("rst_rreq", o_read_request, 0);
    chk("rst_buflen", o_buffer_length, 0);
    chk("rst_done", {o_done, o_done_id, o_done_bytes, o_error}, 0);

    // Empty FIFO blocks arbitration
    set_len(0, 8);
    i_req = 4'b0001;
    tick();
    chk("empty_block", o_grant, 0);

    // Single requester, length 8
    i_fifo_empty = 1'b0;
    tick();
    chk("s1_rreq", o_read_request, 1);
    chk("s1_grant", o_grant, 4'b0001);
    chk("s1_buflen", o_buffer_length, 8);
    i_ser_valid = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    chk("s1_early", {o_done, o_read_request}, 0);
    tick();
    i_ser_valid = 1'b0;
    chk("s1_done", {o_done, o_done_id, o_error}, {1'b1, 3'd0, 1'b0});
    chk("s1_bytes", o_done_bytes, 8);
    i_req = '0;
    tick();
    chk("s1_pulse", {o_done, o_grant}, 0);

    // Round-robin, all lengths 4
    do_reset();
    for (int k = 0; k < N_REQ; k++) set_len(k, 4);
    i_req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      wait_grant(n);
      if (g > 0) chk("rr_gap", n, COOL + 1);
      chk("rr_grant", o_grant, 4'b0001 << ord[g]);
      chk("rr_rreq", o_read_request, 1);
      stream(4);
      chk("rr_done", {o_done, o_done_id, o_error}, {1'b1, 3'(ord[g]), 1'b0});
      chk("rr_bytes", o_done_bytes, 4);
    end
    i_req = '0;

    // Odd length 5, helper emits three trailing invalid slots
    do_reset();
    set_len(0, 5);
    i_req = 4'b0001;
    tick();
    stream(5);
    chk("odd_done", {o_done, o_done_bytes}, {1'b1, 6'd5});
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (o_grant != '0 || o_read_request) bad = 1'b1;
    end
    chk("odd_quiet", bad, 0);
    tick();
    chk("odd_regrant", o_read_request, 1);
    i_req = '0;

    // Zero length on requester 2
    do_reset();
    set_len(2, 0);
    i_req = 4'b0100;
    tick();
    chk("zero_done", {o_done, o_done_id, o_error}, {1'b1, 3'd2, 1'b0});
    chk("zero_bytes", o_done_bytes, 0);
    chk("zero_grant", o_grant, 4'b0100);
    i_req = '0;
    bad   = o_read_request;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (o_read_request) bad = 1'b1;
    end
    chk("zero_norreq", bad, 0);

    // Underflow: length 12, only 4 bytes arrive
    do_reset();
    set_len(1, 12);
    i_req = 4'b0010;
    tick();
    chk("uf_grant", o_grant, 4'b0010);
    stream(4);
    n = 0;
    do begin
      tick();
      n++;
    end while (!o_done && n < 40);
    chk("uf_latency", n, TIMEOUT);
    chk("uf_done", {o_done, o_done_id, o_error}, {1'b1, 3'd1, 1'b1});
    chk("uf_bytes", o_done_bytes, 4);
    set_len(0, 2);
    set_len(2, 2);
    i_req = 4'b0101;
    wait_grant(n);
    chk("uf_rrptr", o_grant, 4'b0100);

    // Reset mid-STREAM
    do_reset();
    set_len(1, 2);
    i_req = 4'b0010;
    tick();
    stream(2);
    chk("mr_first", {o_done, o_done_id}, {1'b1, 3'd1});
    set_len(1, 10);
    set_len(3, 10);
    i_req = 4'b1010;
    wait_grant(n);
    chk("mr_grant3", o_grant, 4'b1000);
    stream(3);
    chk("mr_stream", {o_grant, o_read_request, o_done}, {4'b1000, 1'b0, 1'b0});
    RESET = 1'b1;
    #1;
    chk("mr_async", {o_grant, o_read_request, o_buffer_length, o_done}, 0);
    bad = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (o_done) bad = 1'b1;
    end
    chk("mr_nodone", bad, 0);
    RESET = 1'b0;
    tick();
    chk("mr_regrant", {o_grant, o_read_request}, {4'b0010, 1'b1});
    i_req = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
